// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and width defaults for the memory copy engine
package dma_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - byte-serial memory copy engine; MEM_COPY_DMA_CHECKSUM_EN adds a written-byte checksum port
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_COPY_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  dma_state_t        state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, count;
  logic              accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      count     <= '0;
      mem_wdata <= '0;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_ptr  <= src_addr;
        dst_ptr  <= dst_addr;
        count    <= len;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        checksum <= '0;
`endif
      end
      if (mem_rd_en) begin
        mem_wdata <= mem_rdata;
      end
      // Pointers advance only on a granted write; wrap is natural overflow.
      if (mem_wr_en) begin
        src_ptr  <= src_ptr + 1'b1;
        dst_ptr  <= dst_ptr + 1'b1;
        count    <= count - 1'b1;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        checksum <= checksum + mem_wdata;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = src_ptr;
        mem_rd_en = mem_gnt;
        if (mem_gnt) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = dst_ptr;
        mem_wr_en = mem_gnt;
        if (mem_gnt) begin
          state_nxt = (count == ADDR_W'(1)) ? DONE : READ;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
